// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite pop controller.
// Holds FSM state encoding, default ROM latency and address-width helper.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POPPED
    } state_t;

    localparam int ROM_LATENCY_DEFAULT = 4;

    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h * 2);
    endfunction

endpackage

// File: rtl/sprite_pop_ctrl_pipe_delay.sv
// Fixed-depth shift register with async active-low reset.
// Used to align the in-sprite flag with palette ROM output.
module pipe_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/sprite_pop_ctrl.sv
// Sprite frame sequencer: pop-frame FSM, image ROM address generation
// and in-sprite flag alignment with the palette ROM output.
module sprite_pop_ctrl
    import sprite_pkg::*;
#(
    parameter int WIDTH           = 256,
    parameter int HEIGHT          = 256,
    parameter int POP_HOLD_FRAMES = 30,
    parameter int ROM_LATENCY     = ROM_LATENCY_DEFAULT
) (
    input  logic                             pixel_clk_in,
    input  logic                             rst_in,
    input  logic [10:0]                      x_in,
    input  logic [9:0]                       y_in,
    input  logic [10:0]                      hcount_in,
    input  logic [9:0]                       vcount_in,
    input  logic                             new_frame_in,
    input  logic                             pop_req_in,
    output logic [addr_w(WIDTH, HEIGHT)-1:0] image_addr_out,
    output logic                             in_sprite_out,
    output logic                             frame_sel_out,
    output logic                             busy_out
);

    localparam int AW = addr_w(WIDTH, HEIGHT);
    localparam logic [AW-1:0] LP_FRAME = AW'(WIDTH * HEIGHT);
    localparam logic [AW-1:0] LP_W     = AW'(WIDTH);
    localparam logic [7:0]    LP_HOLD  = 8'(POP_HOLD_FRAMES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_hold;
    logic [7:0]    w_hold_nxt;
    logic          r_frame_sel;
    logic          r_busy;
    logic [AW-1:0] r_addr;

    // Retrigger reload takes priority over decrement and expiry
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        unique case (r_state)
            IDLE: begin
                if (pop_req_in) begin
                    if (new_frame_in) begin
                        w_state_nxt = POPPED;
                        w_hold_nxt  = LP_HOLD;
                    end else begin
                        w_state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                if (new_frame_in) begin
                    w_state_nxt = POPPED;
                    w_hold_nxt  = LP_HOLD;
                end
            end
            POPPED: begin
                if (pop_req_in) begin
                    w_hold_nxt = LP_HOLD;
                end else if (new_frame_in) begin
                    if (r_hold == 8'd1) begin
                        w_state_nxt = IDLE;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold - 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_frame_sel <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_frame_sel <= (w_state_nxt == POPPED);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    logic [11:0]   w_x_end;
    logic [10:0]   w_y_end;
    logic          w_in_h;
    logic          w_in_v;
    logic          w_in_sprite;
    logic [10:0]   w_dx;
    logic [9:0]    w_dy;
    logic [AW-1:0] w_off;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_addr;

    // Widened end bounds so sprites near the screen edge do not wrap
    assign w_x_end     = {1'b0, x_in} + 12'(WIDTH);
    assign w_y_end     = {1'b0, y_in} + 11'(HEIGHT);
    assign w_in_h      = (hcount_in >= x_in) && ({1'b0, hcount_in} < w_x_end);
    assign w_in_v      = (vcount_in >= y_in) && ({1'b0, vcount_in} < w_y_end);
    assign w_in_sprite = w_in_h && w_in_v;

    assign w_dx   = hcount_in - x_in;
    assign w_dy   = vcount_in - y_in;
    assign w_off  = AW'(w_dx) + AW'(w_dy) * LP_W;
    assign w_base = r_frame_sel ? LP_FRAME : '0;
    assign w_addr = w_in_sprite ? (w_base + w_off) : w_base;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_addr;
        end
    end

    pipe_delay #(
        .DEPTH (ROM_LATENCY + 1),
        .W     (1)
    ) u_in_sprite_dly (
        .i_clk   (pixel_clk_in),
        .i_rst_n (rst_in),
        .i_d     (w_in_sprite),
        .o_q     (in_sprite_out)
    );

    assign image_addr_out = r_addr;
    assign frame_sel_out  = r_frame_sel;
    assign busy_out       = r_busy;

endmodule
